imem_prog_loader: RTL and testbench

//  Hardware program loader for the pipeline. It zero-fills instruction memory, then

---
 rtl/imem_prog_loader_pkg.sv | 17 +
 rtl/imem_prog_loader.sv | 155 +++++++++++++++
 tb/tb_imem_prog_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_prog_loader_pkg.sv
// rtl/imem_prog_loader_pkg.sv - shared loader state encoding and IMEM depth constants
package imem_prog_loader_pkg;

    // Loader phases. The Fetch IMEM wrapper decodes these too, so the encoding is fixed here.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } loader_state_e;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;
    localparam int IMEM_DATA_W = 32;

endpackage

// File: rtl/imem_prog_loader.sv
// rtl/imem_prog_loader.sv - zero-fills IMEM, streams a program in, then releases the core
//  clk, rst (async, active low)
//  start                     : one-cycle pulse, honoured only in IDLE or RUN
//  s_valid/s_data/s_last     : program word stream in, s_ready back
//  imem_we/imem_addr/imem_wdata : IMEM write port
//  core_rst_n                : core reset, low everywhere except RUN
//  busy/done/err/word_cnt    : status
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W   = IMEM_ADDR_W,
    parameter int DATA_W   = IMEM_DATA_W,
    parameter bit CLEAR_EN = 1'b1,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int                HC_W      = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [HC_W-1:0]   HOLD_INIT = HC_W'(RST_HOLD);

    loader_state_e     state, state_d;
    logic              s_ready_d, imem_we_d, core_rst_n_d, busy_d, done_d, err_d;
    logic [ADDR_W-1:0] imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_d;
    logic [ADDR_W:0]   word_cnt_d;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_d;
    logic              handshake;
    logic [ADDR_W-1:0] ptr;

    assign handshake = s_valid & s_ready;
    // Load pointer and word count advance together, so the count doubles as the pointer.
    assign ptr = word_cnt[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_d;
            s_ready    <= s_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            core_rst_n <= core_rst_n_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            word_cnt   <= word_cnt_d;
            hold_cnt   <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        s_ready_d    = s_ready;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        core_rst_n_d = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;
        err_d        = err;
        word_cnt_d   = word_cnt;
        hold_cnt_d   = hold_cnt;

        unique case (state)
            ST_IDLE, ST_RUN: begin
                core_rst_n_d = (state == ST_RUN);
                done_d       = (state == ST_RUN);
                if (start) begin
                    core_rst_n_d = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    word_cnt_d   = '0;
                    imem_addr_d  = '0;
                    imem_wdata_d = '0;
                    if (CLEAR_EN) begin
                        state_d   = ST_CLEAR;
                        imem_we_d = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                // The write to address 0 is issued on entry, so this sweep covers every word once.
                if (imem_addr == LAST_ADDR) begin
                    state_d     = ST_LOAD;
                    imem_addr_d = '0;
                    s_ready_d   = 1'b1;
                end else begin
                    imem_we_d   = 1'b1;
                    imem_addr_d = imem_addr + 1'b1;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr;
                    imem_wdata_d = s_data;
                    word_cnt_d   = word_cnt + 1'b1;
                    // The top word is the last one the pointer may take; a missing s_last there is overflow.
                    if (s_last || (ptr == LAST_ADDR)) begin
                        state_d    = ST_HOLD;
                        s_ready_d  = 1'b0;
                        hold_cnt_d = HOLD_INIT;
                        err_d      = ~s_last;
                    end
                end
            end
            ST_HOLD: begin
                // The first HOLD cycle carries the final write; RST_HOLD further cycles keep the core in reset.
                if (hold_cnt == '0) begin
                    state_d      = ST_RUN;
                    core_rst_n_d = 1'b1;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// tb/tb_imem_prog_loader.sv - randomized self-checking bench for imem_prog_loader
module tb_imem_prog_loader;

    localparam int AW       = 10;
    localparam int DEPTH    = 1 << AW;
    localparam int RST_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst, start, s_valid, s_last;
    logic [31:0]   s_data;
    logic          s_ready, imem_we, core_rst_n, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_cnt;

    imem_prog_loader #(.ADDR_W(AW), .DATA_W(32), .CLEAR_EN(1'b1), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural IMEM plus a log of every write seen on the port.
    logic [31:0]   mem [0:DEPTH-1];
    logic [31:0]   src [0:DEPTH];
    int unsigned   cyc = 0;
    int unsigned   fill_req = 0, fill_ack = 0;
    logic [AW-1:0] wl_addr[$];
    logic [31:0]   wl_data[$];
    int unsigned   wl_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fill_req != fill_ack) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hFFFF_FFFF;
            fill_ack <= fill_req;
        end
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            wl_addr.push_back(imem_addr);
            wl_data.push_back(imem_wdata);
            wl_cyc.push_back(cyc);
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic sample;
        @(negedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_core_rst_n"}, core_rst_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    // Start pulse in cycle S: CLEAR writes addresses 0..DEPTH-1 in cycles S+1..S+DEPTH, LOAD opens at S+DEPTH+1.
    task automatic start_clear(input string tag);
        int unsigned s, seen_cyc;
        int          base, bad, nz, n;
        bit          seen;
        base = wl_addr.size();
        @(posedge clk); #1;
        start = 1'b1;
        s     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        sample();
        chk({tag, "_start_core_rst_n"}, core_rst_n, 0);
        chk({tag, "_start_err"}, err, 0);
        chk({tag, "_start_word_cnt"}, word_cnt, 0);
        chk({tag, "_start_busy"}, busy, 1);
        chk({tag, "_start_done"}, done, 0);
        seen = 1'b0;
        seen_cyc = 0;
        for (int i = 0; i < DEPTH + 20 && !seen; i++) begin
            if (s_ready === 1'b1) begin
                seen = 1'b1;
                seen_cyc = cyc;
            end else begin
                sample();
            end
        end
        chk({tag, "_load_open_cycle"}, seen_cyc, s + DEPTH + 1);
        n = wl_addr.size() - base;
        chk({tag, "_clear_writes"}, n, DEPTH);
        bad = 0;
        for (int i = 0; i < n && i < DEPTH; i++)
            if (wl_addr[base+i] != i[AW-1:0] || wl_data[base+i] != 32'd0 || wl_cyc[base+i] != s + 1 + i) bad++;
        chk({tag, "_clear_pattern"}, bad, 0);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'd0) nz++;
        chk({tag, "_imem_zero"}, nz, 0);
    endtask

    // Drives src[0..n-1]; mode 0 = always valid, 1 = random gaps, 2 = valid pattern 1,0,1,1.
    task automatic stream(input int n, input bit use_last, input int mode, input int start_at,
                          input string tag, output int unsigned last_wr);
        logic [AW-1:0] e_addr[$];
        logic [31:0]   e_data[$];
        int unsigned   e_cyc[$];
        logic [3:0]    pat;
        int            base, idx, k, bad, m;
        bit            rdy;
        pat  = 4'b1101;
        base = wl_addr.size();
        idx  = 0;
        k    = 0;
        rdy  = 1'b1;
        while (idx < n && rdy && k < 4 * n + 50) begin
            @(posedge clk); #1;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = ($urandom_range(0, 3) != 0);
                default: s_valid = (k < 4) ? pat[k] : 1'b1;
            endcase
            s_data = src[idx];
            s_last = use_last && (idx == n - 1);
            start  = (k == start_at);
            sample();
            chk({tag, "_s_ready"}, s_ready, rdy);
            if (s_valid && rdy) begin
                e_addr.push_back(idx[AW-1:0]);
                e_data.push_back(src[idx]);
                e_cyc.push_back(cyc + 1);
                idx++;
                if (s_last || idx == DEPTH) rdy = 1'b0;
            end
            k++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        sample();
        m = wl_addr.size() - base;
        chk({tag, "_load_writes"}, m, e_addr.size());
        bad = 0;
        for (int i = 0; i < m && i < e_addr.size(); i++)
            if (wl_addr[base+i] != e_addr[i] || wl_data[base+i] != e_data[i] || wl_cyc[base+i] != e_cyc[i]) bad++;
        chk({tag, "_load_content"}, bad, 0);
        last_wr = (e_cyc.size() > 0) ? e_cyc[e_cyc.size()-1] : 0;
    endtask

    task automatic check_release(input int unsigned last_wr, input string tag);
        int unsigned rise;
        bit          seen;
        rise = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (core_rst_n === 1'b1) begin
                seen = 1'b1;
                rise = cyc;
            end else begin
                chk({tag, "_hold_s_ready"}, s_ready, 0);
                sample();
            end
        end
        chk({tag, "_release_cycle"}, rise, last_wr + RST_HOLD + 1);
        chk({tag, "_run_done"}, done, 1);
        chk({tag, "_run_busy"}, busy, 0);
        chk({tag, "_run_s_ready"}, s_ready, 0);
    endtask

    task automatic check_image(input int nw, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ((i < nw) ? src[i] : 32'd0)) bad++;
        chk({tag, "_image"}, bad, 0);
    endtask

    initial begin
        int unsigned lw;
        int          n, base;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        sample();
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        sample();
        chk("idle_core_rst_n", core_rst_n, 0);

        // Known three-word program over a dirty IMEM.
        src[0] = 32'h00A0_0093; src[1] = 32'h0050_0113; src[2] = 32'h0020_80B3;
        fill_req++;
        repeat (2) sample();
        start_clear("t1");
        stream(3, 1'b1, 0, -1, "t1", lw);
        check_release(lw, "t1");
        chk("t1_word_cnt", word_cnt, 3);
        chk("t1_err", err, 0);
        check_image(3, "t1");

        // Gap pattern 1,0,1,1 with random data; start from RUN.
        for (int i = 0; i < 3; i++) src[i] = $urandom;
        start_clear("t3");
        stream(3, 1'b1, 2, -1, "t3", lw);
        check_release(lw, "t3");
        chk("t3_word_cnt", word_cnt, 3);
        check_image(3, "t3");

        // Random lengths, random valid gaps, stray start pulses during LOAD.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(20, 80);
            for (int i = 0; i < n; i++) src[i] = $urandom;
            fill_req++;
            repeat (2) sample();
            start_clear($sformatf("rnd%0d", r));
            stream(n, 1'b1, 1, $urandom_range(1, 10), $sformatf("rnd%0d", r), lw);
            check_release(lw, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_word_cnt", r), word_cnt, n);
            chk($sformatf("rnd%0d_err", r), err, 0);
            check_image(n, $sformatf("rnd%0d", r));
        end

        // Overflow: 1025 words with no s_last; upstream keeps offering the extra word.
        for (int i = 0; i <= DEPTH; i++) src[i] = $urandom;
        start_clear("ovf");
        stream(DEPTH + 1, 1'b0, 0, -1, "ovf", lw);
        base = wl_addr.size();
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = src[DEPTH];
        sample();
        check_release(lw, "ovf");
        @(posedge clk); #1;
        s_valid = 1'b0;
        sample();
        chk("ovf_extra_writes", wl_addr.size() - base, 0);
        chk("ovf_err", err, 1);
        chk("ovf_word_cnt", word_cnt, DEPTH);
        check_image(DEPTH, "ovf");

        // Start from RUN clears err and word_cnt; reset mid-LOAD aborts at once.
        for (int i = 0; i < 8; i++) src[i] = $urandom;
        start_clear("t6");
        stream(5, 1'b0, 0, -1, "t5", lw);
        chk("t5_word_cnt_before", word_cnt, 5);
        chk("t5_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) sample();
        chk("t5_after_core_rst_n", core_rst_n, 0);
        chk("t5_after_busy", busy, 0);
        chk("t5_after_imem_we", imem_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
